// File: rtl/avalon_to_axi4_master.sv
// Avalon-MM slave to AXI4 master bridge: single-beat 32-bit transfers, one outstanding transaction.
// Avalon requests are registered in IDLE, replayed on AXI, and acknowledged with a one-cycle ACK.
module avalon_to_axi4_master #(
  parameter logic [7:0] AXI_ID = 8'h00
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  // Avalon-MM slave side
  input  logic        avl_cs,
  input  logic        avl_write,
  input  logic        avl_read,
  input  logic [31:0] avl_addr,
  input  logic [31:0] avl_writedata,
  input  logic [3:0]  avl_byteenable,
  output logic [31:0] avl_readdata,
  output logic        avl_waitrequest,
  output logic        avl_readdatavalid,
  output logic [1:0]  avl_response,
  // AXI4 write address
  output logic [7:0]  m_axi_awid,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic [1:0]  m_axi_awlock,
  output logic [3:0]  m_axi_awcache,
  output logic [2:0]  m_axi_awprot,
  output logic [3:0]  m_axi_awqos,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  // AXI4 write data
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  // AXI4 write response
  input  logic [7:0]  m_axi_bid,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  // AXI4 read address
  output logic [7:0]  m_axi_arid,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic [1:0]  m_axi_arlock,
  output logic [3:0]  m_axi_arcache,
  output logic [2:0]  m_axi_arprot,
  output logic [3:0]  m_axi_arqos,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  // AXI4 read data
  input  logic [7:0]  m_axi_rid,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WR, WAIT_B, RD, WAIT_R, ACK} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic        is_read_q;
  logic        aw_done;
  logic        w_done;

  // Single-beat transfers: IDs and returned-beat qualifiers carry no information here.
  logic unused_inputs;
  assign unused_inputs = ^{avl_addr[1:0], m_axi_bid, m_axi_rid, m_axi_rlast};

  assign m_axi_awid    = AXI_ID;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'h00;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 2'b00;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'h0;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = strb_q;
  assign m_axi_wlast   = 1'b1;

  assign m_axi_arid    = AXI_ID;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'h00;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 2'b00;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'h0;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state <= IDLE;
    else              state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt         = state;
    m_axi_awvalid     = 1'b0;
    m_axi_wvalid      = 1'b0;
    m_axi_bready      = 1'b0;
    m_axi_arvalid     = 1'b0;
    m_axi_rready      = 1'b0;
    avl_waitrequest   = 1'b1;
    avl_readdatavalid = 1'b0;
    case (state)
      IDLE: begin
        if (avl_cs && avl_write)     state_nxt = WR;
        else if (avl_cs && avl_read) state_nxt = RD;
      end
      WR: begin
        // AW and W complete independently; leave once both have handshaken.
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_nxt = WAIT_B;
      end
      WAIT_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nxt = ACK;
      end
      RD: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = WAIT_R;
      end
      WAIT_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_nxt = ACK;
      end
      ACK: begin
        avl_waitrequest   = 1'b0;
        avl_readdatavalid = is_read_q;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      is_read_q    <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      avl_readdata <= '0;
      avl_response <= '0;
    end else begin
      case (state)
        IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          // Write has priority when both requests are raised together.
          if (avl_cs && avl_write) begin
            addr_q    <= {avl_addr[31:2], 2'b00};
            wdata_q   <= avl_writedata;
            strb_q    <= avl_byteenable;
            is_read_q <= 1'b0;
          end else if (avl_cs && avl_read) begin
            addr_q    <= {avl_addr[31:2], 2'b00};
            is_read_q <= 1'b1;
          end
        end
        WR: begin
          if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
          if (m_axi_wvalid && m_axi_wready)   w_done  <= 1'b1;
        end
        WAIT_B: begin
          if (m_axi_bvalid) avl_response <= m_axi_bresp;
        end
        WAIT_R: begin
          if (m_axi_rvalid) begin
            avl_readdata <= m_axi_rdata;
            avl_response <= m_axi_rresp;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_to_axi4_master.sv
// Self-checking bench for avalon_to_axi4_master: directed vector table, reset sequence,
// and randomized transactions checked against a transaction-level timing/response model.
`timescale 1ns/1ps
module tb_avalon_to_axi4_master;

  localparam logic [7:0]  ID       = 8'h5A;
  localparam logic [33:0] CONST_AX = {ID, 8'h00, 3'b010, 2'b01, 2'b00, 4'b0011, 3'b000, 4'h0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        avl_cs, avl_write, avl_read;
  logic [31:0] avl_addr, avl_writedata, avl_readdata;
  logic [3:0]  avl_byteenable;
  logic        avl_waitrequest, avl_readdatavalid;
  logic [1:0]  avl_response;
  logic [7:0]  awid, awlen, arid, arlen;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, awlock, arburst, arlock, bresp, rresp;
  logic [3:0]  awcache, awqos, arcache, arqos, wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [7:0]  bid, rid;

  always #5 clk = ~clk;

  avalon_to_axi4_master #(.AXI_ID(ID)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .avl_cs(avl_cs), .avl_write(avl_write), .avl_read(avl_read),
    .avl_addr(avl_addr), .avl_writedata(avl_writedata), .avl_byteenable(avl_byteenable),
    .avl_readdata(avl_readdata), .avl_waitrequest(avl_waitrequest),
    .avl_readdatavalid(avl_readdatavalid), .avl_response(avl_response),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  typedef struct {
    logic        cs, wr, rd, scramble;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic [1:0]  resp;
    int          aw_d, w_d, ar_d, b_d, r_d;
  } txn_t;

  typedef struct {
    int          ack, rdv, aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    int          aw_first, w_first, ar_first, b_first, r_first;
    logic [1:0]  resp;
    logic [31:0] rdata, awaddr, araddr, wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic [33:0] aw_const, ar_const;
  } res_t;

  typedef struct {
    txn_t        t;
    int          ack;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          rdv;
  } vec_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_rdata  = '0;
  logic [1:0]  m_resp   = '0;
  vec_t        vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic res_t blank();
    res_t r;
    r.ack = -1; r.rdv = 0; r.aw_cnt = 0; r.w_cnt = 0; r.ar_cnt = 0; r.b_cnt = 0; r.r_cnt = 0;
    r.aw_first = -1; r.w_first = -1; r.ar_first = -1; r.b_first = -1; r.r_first = -1;
    r.resp = '0; r.rdata = '0; r.awaddr = '0; r.araddr = '0; r.wdata = '0;
    r.wstrb = '0; r.wlast = 1'b0; r.aw_const = '0; r.ar_const = '0;
    return r;
  endfunction

  function automatic txn_t mk(logic cs, logic wr, logic rd, logic [31:0] addr, logic [31:0] wd,
                              logic [3:0] be, int aw_d, int w_d, int ar_d, int b_d, int r_d,
                              logic [1:0] resp, logic [31:0] rd_data, logic scramble);
    txn_t t;
    t.cs = cs; t.wr = wr; t.rd = rd; t.addr = addr; t.wdata = wd; t.be = be;
    t.aw_d = aw_d; t.w_d = w_d; t.ar_d = ar_d; t.b_d = b_d; t.r_d = r_d;
    t.resp = resp; t.rdata = rd_data; t.scramble = scramble;
    return t;
  endfunction

  // Transaction-level model: cycle offsets relative to the cycle the request is presented.
  task automatic predict(input txn_t t, output res_t e);
    int d;
    e = blank();
    e.resp  = m_resp;
    e.rdata = m_rdata;
    if (t.cs && t.wr) begin
      d = (t.aw_d > t.w_d) ? t.aw_d : t.w_d;
      e.aw_first = 1; e.w_first = 1;
      e.aw_cnt = t.aw_d + 1; e.w_cnt = t.w_d + 1;
      e.b_first = 2 + d; e.b_cnt = t.b_d + 1;
      e.ack = 3 + d + t.b_d;
      e.resp = t.resp;
      e.awaddr = t.addr & 32'hFFFF_FFFC;
      e.wdata = t.wdata; e.wstrb = t.be; e.wlast = 1'b1; e.aw_const = CONST_AX;
    end else if (t.cs && t.rd) begin
      e.ar_first = 1; e.ar_cnt = t.ar_d + 1;
      e.r_first = 2 + t.ar_d; e.r_cnt = t.r_d + 1;
      e.ack = 3 + t.ar_d + t.r_d;
      e.resp = t.resp; e.rdata = t.rdata; e.rdv = 1;
      e.araddr = t.addr & 32'hFFFF_FFFC; e.ar_const = CONST_AX;
    end
    m_resp  = e.resp;
    m_rdata = e.rdata;
  endtask

  task automatic slave_idle();
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0; bid = 0; rid = 0; rlast = 0;
  endtask

  // Presents one Avalon request and plays a delay-configurable AXI slave; starts/ends #1 after posedge.
  task automatic run_txn(input txn_t t, output res_t o);
    int  aw_seen = 0, w_seen = 0, ar_seen = 0, b_wait = 0, r_wait = 0;
    bit  aw_ok = 0, w_ok = 0, ar_ok = 0, b_taken = 0, r_taken = 0;
    bit  hs_aw, hs_w, hs_ar, hs_b, hs_r, v_aw, v_w, v_ar;
    int  budget;
    o = blank();
    budget = (t.cs && (t.wr || t.rd)) ? 80 : 8;
    avl_cs = t.cs; avl_write = t.wr; avl_read = t.rd;
    avl_addr = t.addr; avl_writedata = t.wdata; avl_byteenable = t.be;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      v_aw = awvalid; v_w = wvalid; v_ar = arvalid;
      if (awvalid) begin
        o.aw_cnt++;
        if (o.aw_first < 0) begin o.aw_first = k; o.awaddr = awaddr;
          o.aw_const = {awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos}; end
      end
      if (wvalid) begin
        o.w_cnt++;
        if (o.w_first < 0) begin o.w_first = k; o.wdata = wdata; o.wstrb = wstrb; o.wlast = wlast; end
      end
      if (arvalid) begin
        o.ar_cnt++;
        if (o.ar_first < 0) begin o.ar_first = k; o.araddr = araddr;
          o.ar_const = {arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos}; end
      end
      if (bready) begin o.b_cnt++; if (o.b_first < 0) o.b_first = k; end
      if (rready) begin o.r_cnt++; if (o.r_first < 0) o.r_first = k; end
      if (avl_readdatavalid) o.rdv++;
      if (!avl_waitrequest && o.ack < 0) begin
        o.ack = k; o.resp = avl_response; o.rdata = avl_readdata;
      end
      awready = v_aw && (aw_seen >= t.aw_d);
      wready  = v_w  && (w_seen  >= t.w_d);
      arready = v_ar && (ar_seen >= t.ar_d);
      bvalid  = aw_ok && w_ok && !b_taken && (b_wait >= t.b_d);
      rvalid  = ar_ok && !r_taken && (r_wait >= t.r_d);
      bresp = t.resp; rresp = t.resp; rdata = t.rdata;
      bid = 8'($urandom); rid = 8'($urandom); rlast = 1'($urandom);
      hs_aw = v_aw && awready; hs_w = v_w && wready; hs_ar = v_ar && arready;
      hs_b = bvalid && bready; hs_r = rvalid && rready;
      @(posedge clk);
      if (aw_ok && w_ok) b_wait++;
      if (ar_ok) r_wait++;
      if (hs_aw) aw_ok = 1; else if (v_aw) aw_seen++;
      if (hs_w)  w_ok  = 1; else if (v_w)  w_seen++;
      if (hs_ar) ar_ok = 1; else if (v_ar) ar_seen++;
      if (hs_b) b_taken = 1;
      if (hs_r) r_taken = 1;
      #1;
      slave_idle();
      if (o.ack >= 0) break;
      if (t.scramble) begin
        avl_addr = $urandom; avl_writedata = $urandom; avl_byteenable = 4'($urandom);
      end
    end
    if (o.ack < 0) begin o.resp = avl_response; o.rdata = avl_readdata; end
    avl_cs = 0; avl_write = 0; avl_read = 0;
  endtask

  task automatic apply(input string tag, input txn_t t, input res_t e);
    res_t o;
    run_txn(t, o);
    check({tag, ".ack"}, o.ack, e.ack);
    check({tag, ".resp"}, o.resp, e.resp);
    check({tag, ".readdata"}, o.rdata, e.rdata);
    check({tag, ".rdv_cnt"}, o.rdv, e.rdv);
    check({tag, ".aw_cnt"}, o.aw_cnt, e.aw_cnt);
    check({tag, ".w_cnt"}, o.w_cnt, e.w_cnt);
    check({tag, ".ar_cnt"}, o.ar_cnt, e.ar_cnt);
    check({tag, ".bready_cnt"}, o.b_cnt, e.b_cnt);
    check({tag, ".rready_cnt"}, o.r_cnt, e.r_cnt);
    if (e.aw_first >= 0) begin
      check({tag, ".aw_first"}, o.aw_first, e.aw_first);
      check({tag, ".w_first"}, o.w_first, e.w_first);
      check({tag, ".bready_first"}, o.b_first, e.b_first);
      check({tag, ".awaddr"}, o.awaddr, e.awaddr);
      check({tag, ".wdata"}, o.wdata, e.wdata);
      check({tag, ".wstrb"}, o.wstrb, e.wstrb);
      check({tag, ".wlast"}, o.wlast, e.wlast);
      check({tag, ".aw_const"}, o.aw_const, e.aw_const);
    end
    if (e.ar_first >= 0) begin
      check({tag, ".ar_first"}, o.ar_first, e.ar_first);
      check({tag, ".rready_first"}, o.r_first, e.r_first);
      check({tag, ".araddr"}, o.araddr, e.araddr);
      check({tag, ".ar_const"}, o.ar_const, e.ar_const);
    end
  endtask

  task automatic add(input txn_t t, input int ack, input logic [1:0] resp,
                     input logic [31:0] rd_data, input int rdv);
    vec_t v;
    v.t = t; v.ack = ack; v.resp = resp; v.rdata = rd_data; v.rdv = rdv;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    res_t e;
    txn_t t;
    rst_n = 0;
    avl_cs = 0; avl_write = 0; avl_read = 0;
    avl_addr = 0; avl_writedata = 0; avl_byteenable = 0;
    slave_idle();

    //    cs wr rd addr          wdata         be    aw w ar b r resp   rdata          scr   ack resp   readdata      rdv
    add(mk(1, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,          0), 3, 2'b00, 32'h0,          0);
    add(mk(1, 0, 1, 32'h0000_0014, 32'h0,         4'h0, 0, 0, 3, 0, 0, 2'b00, 32'h1234_5678, 0), 6, 2'b00, 32'h1234_5678, 1);
    add(mk(1, 1, 0, 32'h0000_0020, 32'h0BAD_F00D, 4'h3, 3, 0, 0, 0, 0, 2'b00, 32'h0,          0), 6, 2'b00, 32'h1234_5678, 0);
    add(mk(1, 1, 1, 32'h0000_001C, 32'hCAFE_0001, 4'hC, 0, 0, 0, 0, 0, 2'b00, 32'h0,          0), 3, 2'b00, 32'h1234_5678, 0);
    add(mk(1, 0, 1, 32'h0000_0024, 32'h0,         4'h0, 0, 0, 0, 0, 1, 2'b10, 32'h55AA_55AA, 0), 4, 2'b10, 32'h55AA_55AA, 1);
    add(mk(1, 1, 0, 32'h0000_0028, 32'h0000_0001, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,          0), 3, 2'b00, 32'h55AA_55AA, 0);
    add(mk(1, 1, 0, 32'h0000_0033, 32'h7777_8888, 4'h9, 1, 2, 0, 2, 0, 2'b01, 32'h0,          1), 7, 2'b01, 32'h55AA_55AA, 0);
    add(mk(0, 0, 1, 32'h0000_0040, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b11, 32'h9999_9999, 0), -1, 2'b01, 32'h55AA_55AA, 0);
    add(mk(1, 0, 1, 32'hFFFF_FFFF, 32'h0,         4'h0, 0, 0, 0, 0, 2, 2'b11, 32'hFFFF_FFFF, 1), 5, 2'b11, 32'hFFFF_FFFF, 1);

    #1;
    check("reset.waitrequest", avl_waitrequest, 1'b1);
    check("reset.readdatavalid", avl_readdatavalid, 1'b0);
    check("reset.valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    check("reset.readdata", avl_readdata, 32'h0);
    check("reset.response", avl_response, 2'b00);
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      predict(vecs[i].t, e);
      e.ack = vecs[i].ack; e.resp = vecs[i].resp; e.rdata = vecs[i].rdata; e.rdv = vecs[i].rdv;
      apply($sformatf("vec%0d", i), vecs[i].t, e);
    end

    // Reset asserted while the bridge waits for a write response.
    avl_cs = 1; avl_write = 1; avl_addr = 32'h0000_0044;
    avl_writedata = 32'h1111_2222; avl_byteenable = 4'hF;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_seq.awvalid", awvalid, 1'b1);
    awready = 1; wready = 1;
    @(posedge clk); #1;
    awready = 0; wready = 0;
    @(negedge clk);
    check("rst_seq.bready_before", bready, 1'b1);
    bvalid = 1; bresp = 2'b11;
    #2 rst_n = 0;
    #1;
    avl_cs = 0; avl_write = 0;
    check("rst_seq.bready", bready, 1'b0);
    check("rst_seq.valids", {awvalid, wvalid, arvalid, rready}, 4'b0);
    check("rst_seq.waitrequest", avl_waitrequest, 1'b1);
    check("rst_seq.readdatavalid", avl_readdatavalid, 1'b0);
    check("rst_seq.readdata", avl_readdata, 32'h0);
    check("rst_seq.response", avl_response, 2'b00);
    check("rst_seq.regs", {awaddr, wdata, wstrb}, 68'h0);
    @(posedge clk); @(negedge clk);
    check("rst_seq.no_ack", avl_waitrequest, 1'b1);
    rst_n = 1; bvalid = 0; bresp = 0;
    @(posedge clk); #1;
    m_rdata = '0; m_resp = '0;
    t = mk(1, 1, 0, 32'h0000_0048, 32'hA5A5_0F0F, 4'h6, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    predict(t, e);
    e.ack = 3;
    apply("post_reset", t, e);

    for (int i = 0; i < 40; i++) begin
      t = mk(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), $urandom, $urandom,
             4'($urandom), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
             $urandom_range(0, 4), $urandom_range(0, 4), 2'($urandom), $urandom, 1'($urandom));
      predict(t, e);
      apply($sformatf("rnd%0d", i), t, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/avalon_to_axi4_master.md
AVALON_TO_AXI4_MASTER -- requirements
Module: avalon_to_axi4_master

Interface
REQ-001 Parameter AXI_ID, default 8'h00: constant value driven on m_axi_awid and m_axi_arid.
REQ-002 axi_aclk  in  1  sole clock; every flop is rising-edge.
REQ-003 axi_aresetn  in  1  asynchronous, active-low reset.
REQ-004 avl_cs  in  1  Avalon slave chip select; a request is valid only when avl_cs=1.
REQ-005 avl_write / avl_read  in  1 each  Avalon transfer requests.
REQ-006 avl_addr  in  32  byte address.
REQ-007 avl_writedata  in  32  write data.
REQ-008 avl_byteenable  in  4  byte lanes.
REQ-009 avl_readdata  out  32  read data, registered.
REQ-010 avl_waitrequest  out  1  stall; low only in the completion cycle.
REQ-011 avl_readdatavalid  out  1  single-cycle read-data strobe.
REQ-012 avl_response  out  2  captured BRESP or RRESP of the last completed transfer.
REQ-013 m_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,valid}  out  8/32/8/3/2/2/4/3/4/1; m_axi_awready  in  1.
REQ-014 m_axi_w{data,strb,last,valid}  out  32/4/1/1; m_axi_wready  in  1.
REQ-015 m_axi_b{id,resp,valid}  in  8/2/1; m_axi_bready  out  1.
REQ-016 m_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,valid}  out  8/32/8/3/2/2/4/3/4/1; m_axi_arready  in  1.
REQ-017 m_axi_r{id,data,resp,last,valid}  in  8/32/2/1/1; m_axi_rready  out  1.

Function
REQ-018 FSM states SHALL be IDLE, WR, WAIT_B, RD, WAIT_R and ACK; there is one outstanding transaction at most.
REQ-019 Constant outputs SHALL be: len=0, size=3'b010, burst=2'b01, lock=0, cache=4'b0011, prot=3'b000, qos=0, wlast=1.
REQ-020 IDLE: on avl_cs&avl_write, register addr {avl_addr[31:2],2'b00}, data and strb, then go to WR; on avl_cs&avl_read (no write), register addr and go to RD; when write and read are both set, write wins and read is ignored.
REQ-021 WR: assert awvalid and wvalid from the next cycle.
  - Each valid drops after its own handshake (track aw_done, w_done).
  - Go to WAIT_B once both have completed, same cycle or any order.
  - Valids never drop before ready.
REQ-022 RD: assert arvalid until arready, then go to WAIT_R.
REQ-023 WAIT_B: bready=1; on bvalid, capture bresp into avl_response and go to ACK. WAIT_R: rready=1; on rvalid, capture rdata into avl_readdata and rresp into avl_response, then go to ACK; bid, rid and rlast are ignored.
REQ-024 bready/rready SHALL be 0 outside WAIT_B/WAIT_R; B/R beats arriving elsewhere are not accepted.
REQ-025 ACK lasts exactly one cycle:
  - avl_waitrequest=0.
  - avl_readdatavalid=1 only if the completed transfer was a read.
  - Next state is IDLE.
REQ-026 avl_waitrequest SHALL be 1 in every state except ACK.
REQ-027 Latency, request sampled in IDLE at cycle N with zero-wait AXI slave:
  - AXI valid(s) at N+1.
  - bready/rready at N+2.
  - ACK at N+3.
  - Next request accepted at N+4.
  - Each AXI wait cycle adds one cycle.
REQ-028 Non-OKAY responses complete normally; the error is reported via avl_response only. There is no timeout; the FSM waits indefinitely.
REQ-029 Avalon inputs changing while waitrequest=1 violate the protocol; the registered copies are used and the transaction completes.

Reset
REQ-030 Asserting axi_aresetn=0 SHALL immediately force:
  - state to IDLE.
  - all AXI valid/ready outputs to 0.
  - avl_waitrequest to 1 and avl_readdatavalid to 0.
  - avl_readdata, avl_response and the address/data/strb registers to 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no ACK; operation resumes from IDLE on the first clock after deassertion.

Verification
REQ-032 Write 32'hDEADBEEF to 32'h0000_0010, be=4'hF, ready slaves -> awaddr=0x10, wstrb=F, wlast=1; waitrequest low exactly at N+3; avl_response=00.
REQ-033 Read 0x14, rdata=32'h1234_5678 after 3 arready wait cycles -> arvalid held 4 cycles; readdatavalid=1 for one cycle with readdata=32'h12345678.
REQ-034 wready at N+1, awready delayed to N+4 -> wvalid drops at N+2, awvalid held to N+4, bready first asserted at N+5.
REQ-035 Write and read both asserted, addr 0x1C -> only the AW/W channels fire; arvalid stays 0; readdatavalid stays 0.
REQ-036 Read returning rresp=2'b10 -> avl_response=10 at ACK and completes; a following write returning OKAY restores 00.
REQ-037 Reset pulsed while in WAIT_B -> outputs take reset values asynchronously; no ACK occurs; a new write after release follows REQ-027 timing.
